// File: rtl/brick_field_scorer.sv
// Brick-field state and scoring engine: per-brick hit points, combo-multiplied
// saturating score, level progression and floor-loss game over.
module brick_field_scorer #(
  parameter int ROWS       = 7,
  parameter int COLS       = 8,
  parameter int BRICK_W    = 2,
  parameter int TOUGH_ROWS = 2,
  parameter int HP_W       = 2,
  parameter int SCORE_W    = 10,
  parameter int FLOOR_ROW  = 11,
  parameter int POS_W      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ball_valid,
  input  logic [POS_W-1:0]       ball_row,
  input  logic [POS_W-1:0]       ball_col,
  input  logic                   paddle_hit,
  output logic [ROWS*COLS-1:0]   bricks,
  output logic [SCORE_W-1:0]     score,
  output logic [2:0]             combo,
  output logic [3:0]             level,
  output logic                   hit,
  output logic [1:0]             state
);

  localparam int NUM_BRICKS = ROWS * COLS;
  localparam int IDX_W      = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;
  localparam int CNT_W      = $clog2(NUM_BRICKS + 1);
  localparam int COL_SHIFT  = $clog2(BRICK_W);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAY    = 2'b01,
    ST_CLEARED = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  state_t              state_reg, state_next;
  logic [HP_W-1:0]     hp_reg    [NUM_BRICKS];
  logic [HP_W-1:0]     hp_next   [NUM_BRICKS];
  logic [HP_W-1:0]     load_hp   [NUM_BRICKS];
  logic [CNT_W-1:0]    remaining_reg, remaining_next;
  logic [SCORE_W-1:0]  score_reg, score_next;
  logic [2:0]          combo_reg, combo_next;
  logic [3:0]          level_reg, level_next;
  logic                hit_reg, hit_next;

  // Ball position decode; the brick index is only meaningful when in_field.
  logic [31:0]         row_ext, col_ext;
  logic                in_field, at_floor;
  logic [IDX_W-1:0]    brick_idx;
  logic [HP_W-1:0]     cur_hp;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic [2:0]          combo_inc;
  logic [3:0]          level_inc;

  assign row_ext   = 32'(ball_row);
  assign col_ext   = 32'(ball_col);
  assign at_floor  = ball_valid && (row_ext >= 32'(FLOOR_ROW));
  assign in_field  = (row_ext >= 32'd1) && (row_ext <= 32'(ROWS)) &&
                     (col_ext < 32'(COLS * BRICK_W));
  assign brick_idx = IDX_W'((row_ext - 32'd1) * 32'(COLS) + (col_ext >> COL_SHIFT));
  assign cur_hp    = in_field ? hp_reg[brick_idx] : '0;

  // Points use the combo value from before this hit; full-width sum then clamp.
  assign score_sum = {1'b0, score_reg} + (SCORE_W+1)'(combo_reg) + (SCORE_W+1)'(1);
  assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign combo_inc = (combo_reg == 3'd7) ? 3'd7 : combo_reg + 3'd1;
  assign level_inc = (level_reg == 4'hF) ? 4'hF : level_reg + 4'd1;

  generate
    for (genvar gi = 0; gi < NUM_BRICKS; gi++) begin : g_brick
      assign load_hp[gi] = (gi < TOUGH_ROWS * COLS) ? HP_W'(2) : HP_W'(1);
      assign bricks[gi]  = |hp_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    hp_next        = hp_reg;
    remaining_next = remaining_reg;
    score_next     = score_reg;
    combo_next     = combo_reg;
    level_next     = level_reg;
    hit_next       = 1'b0;
    case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_next     = ST_PLAY;
          hp_next        = load_hp;
          remaining_next = CNT_W'(NUM_BRICKS);
          score_next     = '0;
          combo_next     = '0;
          level_next     = '0;
        end
      end
      ST_CLEARED: begin
        if (start) begin
          state_next     = ST_PLAY;
          hp_next        = load_hp;
          remaining_next = CNT_W'(NUM_BRICKS);
          combo_next     = '0;
          level_next     = level_inc;
        end
      end
      ST_PLAY: begin
        if (at_floor) begin
          state_next = ST_OVER;
          combo_next = '0;
        end else begin
          if (ball_valid && in_field && (cur_hp != '0)) begin
            hp_next[brick_idx] = cur_hp - HP_W'(1);
            combo_next         = combo_inc;
            hit_next           = 1'b1;
            if (cur_hp == HP_W'(1)) begin
              score_next     = score_sat;
              remaining_next = remaining_reg - CNT_W'(1);
              if (remaining_reg == CNT_W'(1)) state_next = ST_CLEARED;
            end
          end
          // Paddle contact wins over a same-cycle brick hit for the combo.
          if (paddle_hit) combo_next = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      score_reg     <= '0;
      combo_reg     <= '0;
      level_reg     <= '0;
      hit_reg       <= 1'b0;
      for (int i = 0; i < NUM_BRICKS; i++) hp_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      hp_reg        <= hp_next;
      remaining_reg <= remaining_next;
      score_reg     <= score_next;
      combo_reg     <= combo_next;
      level_reg     <= level_next;
      hit_reg       <= hit_next;
    end
  end

  assign state = state_reg;
  assign score = score_reg;
  assign combo = combo_reg;
  assign level = level_reg;
  assign hit   = hit_reg;

endmodule

// File: tb/tb_brick_field_scorer.sv
// Scoreboard bench for brick_field_scorer: a default instance and a SCORE_W=4
// instance share stimulus and are checked against a grid-level game model.
module tb_brick_field_scorer;

  localparam int ROWS = 7;
  localparam int COLS = 8;
  localparam int BW   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ball_valid = 1'b0;
  logic [3:0]  ball_row = '0;
  logic [3:0]  ball_col = '0;
  logic        paddle_hit = 1'b0;

  logic [55:0] bricks, bricks_s;
  logic [9:0]  score;
  logic [3:0]  score_s;
  logic [2:0]  combo, combo_s;
  logic [3:0]  level, level_s;
  logic        hit, hit_s;
  logic [1:0]  state, state_s;

  always #5 clock = ~clock;

  brick_field_scorer dut (
    .clock(clock), .reset(reset), .start(start), .ball_valid(ball_valid),
    .ball_row(ball_row), .ball_col(ball_col), .paddle_hit(paddle_hit),
    .bricks(bricks), .score(score), .combo(combo), .level(level),
    .hit(hit), .state(state)
  );

  brick_field_scorer #(.SCORE_W(4)) dut_s (
    .clock(clock), .reset(reset), .start(start), .ball_valid(ball_valid),
    .ball_row(ball_row), .ball_col(ball_col), .paddle_hit(paddle_hit),
    .bricks(bricks_s), .score(score_s), .combo(combo_s), .level(level_s),
    .hit(hit_s), .state(state_s)
  );

  typedef struct {
    logic [55:0] bricks;
    int score;
    int score_s;
    int combo;
    int level;
    int hit;
    int state;
  } exp_t;

  exp_t exp_q[$];

  // Game model: hit points per grid row/brick, states 0 idle 1 play 2 cleared 3 over.
  int m_hp [1:7][0:7];
  int m_state, m_score, m_score_s, m_combo, m_level, m_hit;
  int compared = 0;
  int mismatched = 0;
  int txn = 0;

  function automatic void model_fill(input bit load);
    for (int r = 1; r <= ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_hp[r][c] = load ? ((r <= 2) ? 2 : 1) : 0;
  endfunction

  function automatic int bricks_left();
    int n = 0;
    for (int r = 1; r <= ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_hp[r][c] > 0) n++;
    return n;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_step(input bit rst, input bit st, input bit bv,
                                     input int row, input int col, input bit ph);
    m_hit = 0;
    if (rst) begin
      model_fill(0);
      m_state = 0; m_score = 0; m_score_s = 0; m_combo = 0; m_level = 0;
    end else begin
      case (m_state)
        0, 3: if (st) begin
          model_fill(1);
          m_state = 1; m_score = 0; m_score_s = 0; m_combo = 0; m_level = 0;
        end
        2: if (st) begin
          model_fill(1);
          m_state = 1; m_combo = 0; m_level = min_i(m_level + 1, 15);
        end
        default: begin
          if (bv && row >= 11) begin
            m_state = 3;
            m_combo = 0;
          end else begin
            if (bv && row >= 1 && row <= ROWS && col < COLS * BW && m_hp[row][col / BW] > 0) begin
              m_hp[row][col / BW]--;
              if (m_hp[row][col / BW] == 0) begin
                m_score   = min_i(m_score + m_combo + 1, 1023);
                m_score_s = min_i(m_score_s + m_combo + 1, 15);
              end
              m_combo = min_i(m_combo + 1, 7);
              m_hit = 1;
              if (bricks_left() == 0) m_state = 2;
            end
            if (ph) m_combo = 0;
          end
        end
      endcase
    end
  endfunction

  function automatic logic [55:0] model_bricks();
    logic [55:0] v = '0;
    for (int r = 1; r <= ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(r - 1) * COLS + c] = (m_hp[r][c] > 0);
    return v;
  endfunction

  task automatic drive(input bit rst, input bit st, input bit bv,
                       input int row, input int col, input bit ph);
    exp_t e;
    @(negedge clock);
    reset = rst; start = st; ball_valid = bv;
    ball_row = 4'(row); ball_col = 4'(col); paddle_hit = ph;
    model_step(rst, st, bv, row, col, ph);
    e.bricks = model_bricks();
    e.score = m_score; e.score_s = m_score_s; e.combo = m_combo;
    e.level = m_level; e.hit = m_hit; e.state = m_state;
    exp_q.push_back(e);
  endtask

  task automatic random_cycle();
    bit st, bv, ph;
    int row, col;
    st  = ($urandom % 50) == 0;
    bv  = ($urandom % 4) != 0;
    row = (($urandom % 60) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
    col = int'($urandom_range(0, 15));
    ph  = ($urandom % 10) == 0;
    drive(0, st, bv, row, col, ph);
  endtask

  task automatic clear_field();
    if (m_state != 1) drive(0, 1, 0, 0, 0, 0);
    for (int r = 1; r <= ROWS; r++)
      for (int c = 0; c < COLS; c++)
        while (m_state == 1 && m_hp[r][c] > 0)
          drive(0, 0, 1, r, c * BW + int'($urandom_range(0, 1)), ($urandom % 16) == 0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s txn %0d: got %0h expected %0h", name, txn, act, req);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("state",   64'(state),    64'(e.state));
        chk("bricks",  64'(bricks),   64'(e.bricks));
        chk("score",   64'(score),    64'(e.score));
        chk("combo",   64'(combo),    64'(e.combo));
        chk("level",   64'(level),    64'(e.level));
        chk("hit",     64'(hit),      64'(e.hit));
        chk("score_w4", 64'(score_s), 64'(e.score_s));
        chk("state_w4", 64'(state_s), 64'(e.state));
        $display("txn %0d: state=%0d score=%0d score4=%0d combo=%0d level=%0d hit=%0d bricks=%014h",
                 txn, state, score, score_s, combo, level, hit, bricks);
      end
    end
  end

  initial begin
    int guard;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 7, 5, 0);
    drive(0, 0, 1, 7, 6, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 5, 0, 1);
    drive(0, 1, 1, 0, 3, 0);
    drive(0, 0, 1, 8, 3, 0);
    drive(0, 0, 1, 9, 3, 0);
    drive(0, 0, 1, 10, 3, 0);
    drive(0, 0, 1, 7, 0, 0);
    drive(0, 0, 1, 7, 0, 0);
    repeat (250) random_cycle();
    clear_field();
    drive(0, 0, 1, 3, 3, 0);
    drive(0, 1, 0, 0, 0, 0);
    repeat (150) random_cycle();
    if (m_state != 1) drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 4, 4, 0);
    drive(0, 0, 1, 11, 4, 0);
    drive(0, 0, 1, 4, 6, 1);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 6, 2, 0);
    drive(0, 0, 1, 6, 4, 0);
    drive(1, 1, 1, 6, 8, 1);
    drive(0, 0, 1, 6, 8, 0);
    drive(0, 1, 0, 0, 0, 0);
    clear_field();
    drive(0, 1, 0, 0, 0, 0);
    repeat (200) random_cycle();
    drive(0, 0, 0, 0, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
